// File: rtl/capture_engine.sv
// Trigger-based acquisition engine: streams samples into a circular RAM buffer,
// stops after a programmable pre/post split around a masked level/edge trigger.
module capture_engine #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DEPTH      = 1536
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  grant,
  input  logic [1:0]            trig_mode,
  input  logic [DATA_WIDTH-1:0] trig_mask,
  input  logic [DATA_WIDTH-1:0] trig_value,
  input  logic [ADDR_WIDTH-1:0] pre_count,
  input  logic [DATA_WIDTH-1:0] sample_data,
  input  logic                  sample_valid,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_en,
  output logic                  busy,
  output logic                  triggered,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic [ADDR_WIDTH-1:0] start_addr
);

  localparam logic [ADDR_WIDTH-1:0] DEPTH_M1 = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ARMED,
    S_POST,
    S_DONE
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic [ADDR_WIDTH-1:0]   p_reg;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [1:0]              mode_r;
  logic [DATA_WIDTH-1:0]   mask_r;
  logic [DATA_WIDTH-1:0]   value_r;
  logic                    prev_valid;
  logic                    prev_match;

  logic                    match;
  logic                    hit;
  logic [ADDR_WIDTH-1:0]   ptr_inc;
  logic [ADDR_WIDTH-1:0]   p_clamp;
  logic [ADDR_WIDTH-1:0]   start_calc;
  logic [ADDR_WIDTH-1:0]   post_init;

  // Trigger evaluation and wrap arithmetic for the current sample
  always_comb begin
    match      = ((sample_data ^ value_r) & mask_r) == '0;
    ptr_inc    = (ptr == DEPTH_M1) ? '0 : ptr + ONE;
    p_clamp    = (pre_count > DEPTH_M1) ? DEPTH_M1 : pre_count;
    start_calc = (ptr >= p_reg) ? ptr - p_reg : ptr + (DEPTH_M1 - p_reg) + ONE;
    post_init  = DEPTH_M1 - p_reg;
    hit        = 1'b0;
    unique case (mode_r)
      2'd0:    hit = 1'b1;
      2'd1:    hit = match;
      2'd2:    hit = match && prev_valid && !prev_match;
      default: hit = !match && prev_valid && prev_match;
    endcase
  end

  // Capture FSM with registered write port and status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      p_reg      <= '0;
      cnt        <= '0;
      mode_r     <= '0;
      mask_r     <= '0;
      value_r    <= '0;
      prev_valid <= 1'b0;
      prev_match <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_en      <= 1'b0;
      busy       <= 1'b0;
      triggered  <= 1'b0;
      done       <= 1'b0;
      trig_addr  <= '0;
      start_addr <= '0;
    end else begin
      wr_en <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (grant) begin
            mode_r     <= trig_mode;
            mask_r     <= trig_mask;
            value_r    <= trig_value;
            p_reg      <= p_clamp;
            cnt        <= p_clamp;
            ptr        <= '0;
            prev_valid <= 1'b0;
            prev_match <= 1'b0;
            triggered  <= 1'b0;
            busy       <= 1'b1;
            state      <= (p_clamp == '0) ? S_ARMED : S_PRE;
          end
        end

        S_PRE, S_ARMED, S_POST: begin
          if (!grant) begin
            // Abort: drop the capture without completing
            state     <= S_IDLE;
            busy      <= 1'b0;
            triggered <= 1'b0;
          end else if (sample_valid) begin
            wr_en   <= 1'b1;
            wr_addr <= ptr;
            wr_data <= sample_data;
            ptr     <= ptr_inc;
            if (state == S_PRE) begin
              cnt <= cnt - ONE;
              if (cnt == ONE) state <= S_ARMED;
            end else if (state == S_ARMED) begin
              prev_match <= match;
              prev_valid <= 1'b1;
              if (hit) begin
                triggered  <= 1'b1;
                trig_addr  <= ptr;
                start_addr <= start_calc;
                cnt        <= post_init;
                state      <= (post_init == '0) ? S_DONE : S_POST;
              end
            end else begin
              cnt <= cnt - ONE;
              if (cnt == ONE) state <= S_DONE;
            end
          end
        end

        S_DONE: begin
          // busy/done flip one cycle after the final write pulse
          busy <= 1'b0;
          if (!grant) begin
            state     <= S_IDLE;
            done      <= 1'b0;
            triggered <= 1'b0;
          end else begin
            done <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_engine.sv
// Directed bench for capture_engine with DEPTH=16: table of capture scenarios
// plus hand sequences for abort and asynchronous reset.
module tb_capture_engine;

  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 5;
  localparam int unsigned DEP = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          grant;
  logic [1:0]    trig_mode;
  logic [DW-1:0] trig_mask;
  logic [DW-1:0] trig_value;
  logic [AW-1:0] pre_count;
  logic [DW-1:0] sample_data;
  logic          sample_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          busy;
  logic          triggered;
  logic          done;
  logic [AW-1:0] trig_addr;
  logic [AW-1:0] start_addr;

  capture_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .grant(grant), .trig_mode(trig_mode),
    .trig_mask(trig_mask), .trig_value(trig_value), .pre_count(pre_count),
    .sample_data(sample_data), .sample_valid(sample_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .busy(busy),
    .triggered(triggered), .done(done), .trig_addr(trig_addr),
    .start_addr(start_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    mode;
    logic [DW-1:0] mask;
    logic [DW-1:0] value;
    logic [AW-1:0] pre;
    logic [DW-1:0] base;
    int            gap;
    logic [AW-1:0] exp_trig;
    logic [AW-1:0] exp_start;
    int            exp_writes;
    logic [DW-1:0] exp_ram0;
  } vec_t;

  vec_t          vecs [5];
  logic [DW-1:0] ram [DEP];
  int            cyc = 0;
  int            wr_total = 0;
  int            last_wr_cyc = 0;
  int            bad_addr = 0;
  int            total = 0;
  int            bad = 0;

  always @(posedge clk) cyc = cyc + 1;

  // RAM model fed by the write port
  always @(negedge clk) begin
    if (wr_en) begin
      if (int'(wr_addr) >= int'(DEP)) bad_addr = bad_addr + 1;
      else ram[wr_addr] = wr_data;
      wr_total    = wr_total + 1;
      last_wr_cyc = cyc;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t          v;
    logic [DW-1:0] data;
    logic [AW-1:0] idx;
    logic [DW-1:0] expb;
    bit            seen_done;
    int            errs;
    int            w;

    vecs[0] = '{2'd1, 8'hFF, 8'h20, 5'd4,  8'h00, 0, 5'd0, 5'd12, 44, 8'h1C};
    vecs[1] = '{2'd0, 8'hFF, 8'h00, 5'd0,  8'h50, 2, 5'd0, 5'd0,  16, 8'h50};
    vecs[2] = '{2'd1, 8'hFF, 8'h80, 5'd21, 8'h70, 0, 5'd0, 5'd1,  17, 8'h71};
    vecs[3] = '{2'd3, 8'h10, 8'h10, 5'd2,  8'h0C, 3, 5'd4, 5'd2,  34, 8'h1E};
    vecs[4] = '{2'd2, 8'h01, 8'h01, 5'd3,  8'h00, 2, 5'd5, 5'd2,  18, 8'h02};

    rst = 1'b1; grant = 1'b0; trig_mode = '0; trig_mask = '0; trig_value = '0;
    pre_count = '0; sample_data = '0; sample_valid = 1'b0;
    tick(); tick();
    chk("reset_outputs", 32'({wr_addr, wr_data, wr_en, busy, triggered, done,
                              trig_addr, start_addr}), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    for (int s = 0; s < 5; s++) begin
      v = vecs[s];
      for (int i = 0; i < int'(DEP); i++) ram[i] = 8'hEE;
      wr_total = 0;
      trig_mode = v.mode; trig_mask = v.mask; trig_value = v.value;
      pre_count = v.pre; sample_valid = 1'b0; grant = 1'b1;
      tick();
      chk($sformatf("busy_on[%0d]", s), 32'(busy), 32'd1);
      data = v.base;
      seen_done = 1'b0;
      for (int c = 0; c < 300 && !seen_done; c++) begin
        sample_data  = data;
        sample_valid = (v.gap == 0) || ((c % v.gap) != v.gap - 1);
        tick();
        if (sample_valid) data = data + 8'd1;
        if (done) seen_done = 1'b1;
      end
      sample_valid = 1'b0;
      if (!seen_done) begin
        chk($sformatf("done_timeout[%0d]", s), 32'd0, 32'd1);
      end else begin
        chk($sformatf("done_lag[%0d]", s), 32'(cyc - last_wr_cyc), 32'd1);
        chk($sformatf("busy_at_done[%0d]", s), 32'({busy, wr_en}), 32'd0);
        chk($sformatf("trig_addr[%0d]", s), 32'(trig_addr), 32'(v.exp_trig));
        chk($sformatf("start_addr[%0d]", s), 32'(start_addr), 32'(v.exp_start));
        chk($sformatf("triggered[%0d]", s), 32'(triggered), 32'd1);
        chk($sformatf("writes[%0d]", s), 32'(wr_total), 32'(v.exp_writes));
        errs = 0;
        for (int i = 0; i < int'(DEP); i++) begin
          idx  = AW'((int'(v.exp_start) + i) % int'(DEP));
          expb = DW'(int'(v.exp_ram0) + i);
          if (ram[idx] !== expb) errs++;
        end
        chk($sformatf("ram_contents[%0d]", s), 32'(errs), 32'd0);
        w = wr_total;
        sample_valid = 1'b1;
        tick(); tick(); tick();
        sample_valid = 1'b0;
        chk($sformatf("done_hold[%0d]", s), 32'({done, trig_addr}), 32'({1'b1, v.exp_trig}));
        chk($sformatf("no_write_in_done[%0d]", s), 32'(wr_total), 32'(w));
        grant = 1'b0;
        tick();
        chk($sformatf("release[%0d]", s), 32'({done, triggered, busy}), 32'd0);
      end
      grant = 1'b0;
      tick();
    end

    // Abort after trigger, final sample coinciding with grant drop
    wr_total = 0;
    trig_mode = 2'd0; pre_count = '0; grant = 1'b1; sample_valid = 1'b0;
    tick();
    sample_valid = 1'b1; sample_data = 8'hA0;
    tick(); tick(); tick();
    chk("abort_trig_seen", 32'(triggered), 32'd1);
    grant = 1'b0;
    tick();
    chk("abort_status", 32'({busy, wr_en, triggered}), 32'd0);
    w = wr_total;
    tick(); tick(); tick(); tick();
    chk("abort_no_writes", 32'(wr_total), 32'(w));
    chk("abort_writes_before", 32'(w), 32'd3);
    chk("abort_no_done", 32'(done), 32'd0);
    sample_valid = 1'b0; grant = 1'b1;
    tick();
    chk("regrant", 32'({busy, triggered}), 32'({1'b1, 1'b0}));
    grant = 1'b0;
    tick();

    // Asynchronous reset while writing in POST
    trig_mode = 2'd0; pre_count = '0; grant = 1'b1; sample_valid = 1'b0;
    tick();
    sample_valid = 1'b1;
    tick(); tick(); tick();
    chk("post_before_rst", 32'({wr_en, busy, triggered}), 32'h7);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", 32'({wr_addr, wr_data, wr_en, busy, triggered, done,
                          trig_addr, start_addr}), 32'd0);
    sample_valid = 1'b0; grant = 1'b0;
    #1 rst = 1'b0;
    tick();
    chk("idle_after_rst", 32'({busy, done, wr_en}), 32'd0);
    grant = 1'b1;
    tick();
    chk("restart_after_rst", 32'(busy), 32'd1);
    grant = 1'b0;
    tick();

    chk("addr_range", 32'(bad_addr), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/capture_engine.md
# capture_engine

Single-clock, parametrised acquisition engine with trigger and pre-trigger capture. It replaces the fixed-length "grant → fill RAM → done" acquirer. Samples stream into an external simple-dual-port RAM as a circular buffer. A masked level or edge trigger stops the capture after a programmable pre/post split, and the block reports where the oldest sample and the trigger sample sit. It is driven by the task dispatcher's grant/done handshake. The transmit block reads the RAM back starting at `start_addr`.

## Interface
- `DATA_WIDTH`, 8, sample and RAM word width
- `ADDR_WIDTH`, 11, RAM address width
- `DEPTH`, 1536, buffer length in samples; must be ≤ 2^ADDR_WIDTH and ≥ 2; need not be a power of two

Ports:
- `clk` in 1: sole clock
- `rst` in 1: asynchronous, active-high reset
- `grant` in 1: level; high = capture permitted
- `trig_mode` in 2: 0 immediate, 1 level, 2 rising, 3 falling
- `trig_mask` in DATA_WIDTH: bits participating in the match
- `trig_value` in DATA_WIDTH: match value
- `pre_count` in ADDR_WIDTH: samples kept before the trigger
- `sample_data` in DATA_WIDTH: incoming sample
- `sample_valid` in 1: sample strobe, one sample per high cycle
- `wr_addr` out ADDR_WIDTH: RAM write address
- `wr_data` out DATA_WIDTH: RAM write data
- `wr_en` out 1: RAM write enable
- `busy` out 1: capture in progress
- `triggered` out 1: trigger has occurred in the current capture
- `done` out 1: capture complete
- `trig_addr` out ADDR_WIDTH: RAM address of the trigger sample
- `start_addr` out ADDR_WIDTH: RAM address of the oldest valid sample

## Operation
- Match is defined as `match = ((sample_data ^ trig_value) & trig_mask) == 0`.
- **IDLE**
  - When `grant`=1, latch `trig_mode`, `trig_mask`, `trig_value` and `P` = min(`pre_count`, DEPTH-1).
  - Clear the write pointer, `prev_valid` and `triggered`, then go to PRE.
- **PRE**
  - Write each valid sample at the pointer and increment the pointer.
  - The trigger is not evaluated in this state.
  - After P writes, go to ARMED. If P=0, go straight from IDLE to ARMED.
- **ARMED**
  - Write each valid sample; the pointer wraps from DEPTH-1 to 0.
  - Trigger condition by mode:
    - mode 0: any valid sample.
    - mode 1: `match`.
    - mode 2: `match` && `prev_valid` && !`prev_match`.
    - mode 3: !`match` && `prev_valid` && `prev_match`.
  - After every write, `prev_match` ← `match` and `prev_valid` ← 1.
  - On trigger:
    - `trig_addr` ← address of the triggering sample.
    - `start_addr` ← (`trig_addr` − P) mod DEPTH.
    - Set a post counter to DEPTH−P−1 and go to POST.
    - If DEPTH−P−1 = 0, go directly to DONE.
- **POST**
  - Write each valid sample and decrement the counter.
  - When the counter reaches 0 after a write, go to DONE.
- **DONE**
  - Hold `done`=1 with all status stable and `wr_en`=0.
  - When `grant` drops to 0, return to IDLE and drop `done`.
- **Capture contents:** exactly DEPTH samples from `start_addr` wrap-around, with the trigger sample at offset P.
- **Abort:** `grant`=0 in PRE, ARMED or POST returns to IDLE on the next edge. No further writes occur, and `done` never asserts for that capture.
- **Wrap arithmetic:** pointer increment is "`ptr`==DEPTH−1 ? 0 : `ptr`+1". `start_addr` subtraction adds DEPTH when the result would go negative. No other modular arithmetic is used.
- **Status outputs:** `busy` = state ∈ {PRE, ARMED, POST}. `triggered` is set at trigger and cleared on leaving DONE or on abort.

## Timing
- **Reset values:** all outputs are 0, state is IDLE, and all internal registers are 0.
- **Start:** `grant` sampled high in IDLE gives `busy`=1 on the next cycle. Samples are accepted from the cycle after that.
- **Write latency:** a sample accepted at edge N gives `wr_en`/`wr_addr`/`wr_data` registered at N+1, for exactly one cycle.
- **Trigger indication:** `triggered`, `trig_addr` and `start_addr` become valid in the same cycle as `wr_en` for the trigger sample.
- **Completion:** `done` asserts one cycle after the final `wr_en` pulse, and `busy` deasserts in the same cycle.
- **Gaps:** `sample_valid` may have arbitrary gaps. No sample is dropped while `busy` is high.
- **Samples outside a capture:** samples in IDLE or DONE are ignored.
- **Simultaneous `grant` fall and final sample:** the abort wins, there is no write, and the engine goes to IDLE.
- **Reset mid-capture:** the engine returns to IDLE immediately and `wr_en` drops asynchronously.

## Test plan
- DEPTH=16, P=4, mode 1, mask=0xFF, value=0x20, ramp 0x00..0x3F → `trig_addr`=0x20 mod 16=0, `start_addr`=12, 11 post writes, `done` set, RAM holds 0x1C..0x2B.
- Mode 2, mask=0x01, value=0x01, data 0,0,1,1,0,1 after PRE → trigger on the first 1. With the first ARMED sample 1 and no prior sample, no trigger occurs.
- Mode 0 with P=0 → the first sample triggers, `trig_addr`=`start_addr`=0, exactly DEPTH writes at addresses 0..DEPTH−1.
- `pre_count`=DEPTH+5 → clamped to P=DEPTH−1; `done` follows the trigger-sample write by one cycle with no post writes.
- Drop `grant` mid-ARMED → `busy`=0 next cycle, no further `wr_en`, `done` stays 0; re-grant restarts with `triggered`=0.
- Assert `rst` during POST → all outputs 0 asynchronously, and IDLE resumes on release.
